// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between IF/DM requesters, the arbiter and the unified memory.
// ARB_PERF_CNT_EN adds the conflict/stall counter outputs.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_read_type;
  logic [1:0]        dm_write_type;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [2:0]        mem_read_type;
  logic [1:0]        mem_write_type;
  logic [DATA_W-1:0] mem_dout;

`ifdef ARB_PERF_CNT_EN
  logic [31:0]       conflict_cnt;
  logic [31:0]       if_stall_cnt;
`endif

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_read_type, dm_write_type,
    input  mem_dout,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_we, mem_din,
    output mem_read_type, mem_write_type
`ifdef ARB_PERF_CNT_EN
    , output conflict_cnt, if_stall_cnt
`endif
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dm_read_type, dm_write_type,
    output mem_dout,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_we, mem_din,
    input  mem_read_type, mem_write_type
`ifdef ARB_PERF_CNT_EN
    , input conflict_cnt, if_stall_cnt
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter for one single-ported memory, data-first with IF anti-starvation.
// Optional perf counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic vld;
    logic src;
  } tag_t;

  logic [SW-1:0]     starve_q, starve_d;
  tag_t              tag_q [MEM_LAT];
  tag_t              tag_in, tag_out;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              conflict, if_win;
  logic              if_gnt, dm_gnt;
  logic              if_rv, dm_rv;

  always_comb begin
    conflict = bus.if_req & bus.dm_req;
    if_win   = starve_q >= SW'(STARVE_MAX);
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    // no grant while reset is held, even if requests are up
    if (!rst) begin
      if (conflict) begin
        if_gnt = if_win;
        dm_gnt = ~if_win;
      end else begin
        if_gnt = bus.if_req;
        dm_gnt = bus.dm_req;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt)
      starve_d = '0;
    else if (starve_q < SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    bus.mem_addr       = '0;
    bus.mem_we         = 1'b0;
    bus.mem_din        = '0;
    bus.mem_read_type  = '0;
    bus.mem_write_type = '0;
    if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end else if (dm_gnt) begin
      bus.mem_addr       = bus.dm_addr;
      bus.mem_we         = bus.dm_we;
      bus.mem_din        = bus.dm_wdata;
      bus.mem_read_type  = bus.dm_read_type;
      bus.mem_write_type = bus.dm_write_type;
    end
  end

  always_comb begin
    tag_in.vld = if_gnt | (dm_gnt & ~bus.dm_we);
    tag_in.src = dm_gnt;
    tag_out    = tag_q[MEM_LAT-1];
    if_rv      = tag_out.vld & ~tag_out.src;
    dm_rv      = tag_out.vld & tag_out.src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      for (int i = 0; i < MEM_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  // hold registers keep the last return of each side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rv)
        if_rdata_q <= bus.mem_dout;
      if (dm_rv)
        dm_rdata_q <= bus.mem_dout;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rv;
  assign bus.dm_rvalid = dm_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_dout : if_rdata_q;
  assign bus.dm_rdata  = dm_rv ? bus.mem_dout : dm_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, if_stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      if_stall_cnt_q <= '0;
    end else begin
      if (conflict)
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      if (bus.if_req && !if_gnt)
        if_stall_cnt_q <= if_stall_cnt_q + 32'd1;
    end
  end

  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.if_stall_cnt = if_stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1, one at MEM_LAT=2, read scoreboard.
// Memory is modelled as data = f(addr) returned MEM_LAT cycles after issue.
module tb_mem_port_arbiter;
  typedef struct {
    int          due;
    bit          src;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   compared;
  int   mismatched;
  exp_t q1 [$];
  exp_t q2 [$];

  logic [31:0] a1_q;
  logic [31:0] a2_q0, a2_q1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    if (a == 32'h10)
      return 32'h00A0_0093;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    a1_q  <= b1.mem_addr;
    a2_q0 <= b2.mem_addr;
    a2_q1 <= a2_q0;
  end

  assign b1.mem_dout = f(a1_q);
  assign b2.mem_dout = f(a2_q1);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step1(input bit ei, input bit ed);
    exp_t e;
    @(negedge clk);
    chk("if_gnt1", b1.if_gnt, ei);
    chk("dm_gnt1", b1.dm_gnt, ed);
    chk("mem_addr1", b1.mem_addr,
        ei ? b1.if_addr : (ed ? b1.dm_addr : 32'h0));
    chk("mem_we1", b1.mem_we, ed & b1.dm_we);
    chk("mem_din1", b1.mem_din, ed ? b1.dm_wdata : 32'h0);
    chk("mem_rt1", b1.mem_read_type, ed ? b1.dm_read_type : 3'd0);
    chk("mem_wt1", b1.mem_write_type, ed ? b1.dm_write_type : 2'd0);
    e.due = cyc + 1;
    if (ei) begin
      e.src = 1'b0; e.data = f(b1.if_addr); q1.push_back(e);
    end else if (ed && !b1.dm_we) begin
      e.src = 1'b1; e.data = f(b1.dm_addr); q1.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic step2(input bit ei, input bit ed);
    exp_t e;
    @(negedge clk);
    chk("if_gnt2", b2.if_gnt, ei);
    chk("dm_gnt2", b2.dm_gnt, ed);
    chk("mem_addr2", b2.mem_addr,
        ei ? b2.if_addr : (ed ? b2.dm_addr : 32'h0));
    chk("mem_we2", b2.mem_we, ed & b2.dm_we);
    e.due = cyc + 2;
    if (ei) begin
      e.src = 1'b0; e.data = f(b2.if_addr); q2.push_back(e);
    end else if (ed && !b2.dm_we) begin
      e.src = 1'b1; e.data = f(b2.dm_addr); q2.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.if_rvalid || b1.dm_rvalid) begin
      if (q1.size() == 0) begin
        chk("rv1_unexpected", {b1.if_rvalid, b1.dm_rvalid}, 32'h0);
      end else begin
        e = q1.pop_front();
        chk("rv1_both", b1.if_rvalid & b1.dm_rvalid, 32'h0);
        chk("rv1_cycle", cyc, e.due);
        chk("rv1_src", b1.dm_rvalid, e.src);
        chk("rv1_data", e.src ? b1.dm_rdata : b1.if_rdata, e.data);
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      chk("rv1_missing", b1.if_rvalid | b1.dm_rvalid, 32'h1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (b2.if_rvalid || b2.dm_rvalid) begin
      if (q2.size() == 0) begin
        chk("rv2_unexpected", {b2.if_rvalid, b2.dm_rvalid}, 32'h0);
      end else begin
        e = q2.pop_front();
        chk("rv2_both", b2.if_rvalid & b2.dm_rvalid, 32'h0);
        chk("rv2_cycle", cyc, e.due);
        chk("rv2_src", b2.dm_rvalid, e.src);
        chk("rv2_data", e.src ? b2.dm_rdata : b2.if_rdata, e.data);
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      chk("rv2_missing", b2.if_rvalid | b2.dm_rvalid, 32'h1);
      void'(q2.pop_front());
    end
  end

  initial begin
    cyc = 0;
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    b1.if_req = 1'b1; b1.if_addr = 32'h20;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h300;
    b1.dm_wdata = 32'h0; b1.dm_read_type = 3'd5; b1.dm_write_type = 2'd0;
    b2.if_req = 1'b0; b2.if_addr = 32'h0;
    b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = 32'h0;
    b2.dm_wdata = 32'h0; b2.dm_read_type = 3'd0; b2.dm_write_type = 2'd0;

    // reset values with both requests already raised
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", b1.if_gnt, 32'h0);
    chk("rst_dm_gnt", b1.dm_gnt, 32'h0);
    chk("rst_if_rvalid", b1.if_rvalid, 32'h0);
    chk("rst_dm_rvalid", b1.dm_rvalid, 32'h0);
    chk("rst_if_rdata", b1.if_rdata, 32'h0);
    chk("rst_dm_rdata", b1.dm_rdata, 32'h0);
    chk("rst_mem_we", b1.mem_we, 32'h0);
    chk("rst_mem_addr", b1.mem_addr, 32'h0);
    chk("rst_mem_rt", b1.mem_read_type, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous conflict: DM x4 then IF, repeated
    for (int i = 0; i < 10; i++)
      step1(i % 5 == 4, i % 5 != 4);
`ifdef ARB_PERF_CNT_EN
    chk("conflict_cnt", b1.conflict_cnt, 32'd10);
    chk("if_stall_cnt", b1.if_stall_cnt, 32'd8);
`endif

    // dropping if_req clears the starvation count
    step1(0, 1);
    step1(0, 1);
    b1.if_req = 1'b0;
    step1(0, 1);
    b1.if_req = 1'b1;
    for (int i = 0; i < 5; i++)
      step1(i == 4, i != 4);

    // idle: type fields must not leak to memory
    b1.if_req = 1'b0; b1.dm_req = 1'b0;
    b1.dm_read_type = 3'd7; b1.dm_write_type = 2'd3;
    b1.dm_wdata = 32'h1234_5678;
    step1(0, 0);

    // IF-only fetch
    b1.if_req = 1'b1; b1.if_addr = 32'h10;
    step1(1, 0);
    b1.if_req = 1'b0;
    step1(0, 0);
    chk("dm_rdata_hold", b1.dm_rdata, f(32'h300));
    chk("if_rdata_last", b1.if_rdata, 32'h00A0_0093);

    // DM store
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 32'h100;
    b1.dm_wdata = 32'hDEAD_BEEF; b1.dm_write_type = 2'd2;
    step1(0, 1);
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    step1(0, 0);
    step1(0, 0);
    chk("dm_rdata_after_st", b1.dm_rdata, f(32'h300));

    // alternating sources at MEM_LAT=2
    b2.if_req = 1'b1; b2.if_addr = 32'h0;
    step2(1, 0);
    b2.if_req = 1'b0; b2.dm_req = 1'b1; b2.dm_addr = 32'h200;
    step2(0, 1);
    b2.dm_req = 1'b0; b2.if_req = 1'b1; b2.if_addr = 32'h4;
    step2(1, 0);
    b2.if_req = 1'b0;
    repeat (3) step2(0, 0);

    // reset with two reads in flight
    b2.if_req = 1'b1; b2.if_addr = 32'h40;
    step2(1, 0);
    b2.if_req = 1'b0; b2.dm_req = 1'b1; b2.dm_addr = 32'h80;
    step2(0, 1);
    b2.dm_req = 1'b0; b2.if_req = 1'b1; b2.if_addr = 32'h8;
    rst = 1'b1;
    q2.delete();
    @(negedge clk);
    chk("mid_rst_if_gnt", b2.if_gnt, 32'h0);
    chk("mid_rst_if_rvalid", b2.if_rvalid, 32'h0);
    chk("mid_rst_dm_rvalid", b2.dm_rvalid, 32'h0);
    chk("mid_rst_if_rdata", b2.if_rdata, 32'h0);
    chk("mid_rst_dm_rdata", b2.dm_rdata, 32'h0);
    chk("mid_rst_mem_addr", b2.mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step2(1, 0);
    b2.if_req = 1'b0;
    repeat (4) step2(0, 0);

    chk("queues_drained", q1.size() + q2.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between the CPU instruction-fetch requester (IF) and the data-memory requester (DM, MEM stage).
- Grants at most one access per cycle. Tracks in-flight reads with a tag pipeline and returns read data to the correct requester after a fixed latency.
- Data has priority. A starvation counter forces an IF grant after repeated denials.
- Sits between the CPU core's im/mem buses and the MEM block.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from a granted read to valid mem_dout (≥1).
- STARVE_MAX, 4, consecutive IF denials before IF wins the next conflict (≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request
- dm_we  in  1  data write enable
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_read_type  in  3  load size/sign code, passed through
- dm_write_type  in  2  store size code, passed through
- dm_gnt  out  1  data access accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_din  out  DATA_W  memory write data
- mem_read_type  out  3  to memory
- mem_write_type  out  2  to memory
- mem_dout  in  DATA_W  memory read data, MEM_LAT cycles after issue

Behaviour:
- Grant is combinational from the current requests and registered state. The mem_* outputs mux the winner's fields in the same cycle.
- With no grant: mem_we=0; mem_addr, mem_din and the type fields hold 0.
- Only one requester active: that requester is granted.
- Both requesting (conflict):
  - DM wins if starve_cnt < STARVE_MAX.
  - Otherwise IF wins, and starve_cnt clears.
- starve_cnt update per cycle:
  - Increments (saturating at STARVE_MAX) when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Requesters hold req and fields stable until they see gnt. They may drop req without a grant; nothing is issued in that case.
- Writes (dm_we=1): complete in the grant cycle with mem_we=1 for exactly that cycle. A write never produces dm_rvalid.
- Reads:
  - Each granted read pushes a tag {valid, src} into a MEM_LAT-deep shift register.
  - On the cycle the tag exits, the matching rvalid pulses for 1 cycle. The matching rdata equals mem_dout in that cycle.
  - The non-matching rdata holds its last value.
- Throughput: one access per cycle, fully pipelined. Back-to-back reads from alternating sources return in issue order.
- Simultaneous grant and tag exit in the same cycle are independent and both handled.
- Reset values: all gnt, rvalid and mem_we are 0; rdata outputs are 0; mem_* are 0; starve_cnt is 0; tag pipeline is all invalid.
- Reset mid-operation: in-flight read tags are discarded; no rvalid is produced for them after reset releases.
- A change in dm_read_type or dm_write_type only affects mem_* when DM is granted.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - conflict_cnt (32): increments each cycle both requesters are active.
  - if_stall_cnt (32): increments each cycle if_req=1 and if_gnt=0.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports do not exist and the related logic is absent.

Test Plan:
- IF-only read, MEM_LAT=1: if_req=1, if_addr=0x0000_0010, mem returns 0x00A0_0093 -> if_gnt=1 in cycle 0; if_rvalid=1 with if_rdata=0x00A0_0093 in cycle 1; dm_rvalid stays 0.
- Conflict, STARVE_MAX=4: both requesting continuously, DM reads -> dm_gnt for cycles 0-3, if_gnt in cycle 4, then the pattern repeats; rvalids follow issue order one cycle later.
- DM store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, write_type=2 -> mem_we=1 with mem_addr=0x100, mem_din=0xDEAD_BEEF, mem_write_type=2 for 1 cycle; no dm_rvalid.
- Alternating read sources, MEM_LAT=2: IF@0x0, DM@0x200, IF@0x4 in consecutive cycles -> if_rvalid, dm_rvalid, if_rvalid in cycles 2, 3 and 4 carrying the matching mem_dout values.
- Reset mid-flight: assert rst while 2 reads are in flight (MEM_LAT=2) -> all outputs return to 0 immediately; no rvalid after release; the first new request is granted normally.
- With ARB_PERF_CNT_EN: 10 conflict cycles at STARVE_MAX=4 -> conflict_cnt=10 and if_stall_cnt=8.
